// File: rtl/cc_branch_unit.sv
// Condition-code / branch unit: carry and zero flags, the JCN condition
// evaluator, the DCL bank register, and two-word instruction tracking.
// Latency: jump/JMS/DCL strobes are registered one clock after the deciding X3 (cycle 7).
// Backpressure: none; the host stalls by not presenting cycle 7, and state then holds.
//
// Ports: clk/rstN (async active-low); cycle, opr, opa give the current ROM word and
// sub-cycle; testPin, flagWe/carryNext/zeroNext, regZeroIn, accIn and pcIn are the
// condition and operand sources. The outputs are the flags, the combinational ccOut,
// secondWord (operand-word marker for the decoder), the jumpTaken/jmsPush/jumpAddr
// jump interface, and bankSel/bankSelStb.
module cc_branch_unit #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12,
    parameter int BANK_W = 3
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [2:0]        cycle,
    input  logic [3:0]        opr,
    input  logic [3:0]        opa,
    input  logic              testPin,
    input  logic              flagWe,
    input  logic              carryNext,
    input  logic              zeroNext,
    input  logic              regZeroIn,
    input  logic [DATA_W-1:0] accIn,
    input  logic [ADDR_W-1:0] pcIn,
    output logic              carryFlag,
    output logic              zeroFlag,
    output logic              ccOut,
    output logic              secondWord,
    output logic              jumpTaken,
    output logic              jmsPush,
    output logic [ADDR_W-1:0] jumpAddr,
    output logic [BANK_W-1:0] bankSel,
    output logic              bankSelStb
);

    localparam logic [2:0] ST_W1  = 3'd0;
    localparam logic [2:0] ST_JCN = 3'd1;
    localparam logic [2:0] ST_ISZ = 3'd2;
    localparam logic [2:0] ST_JUN = 3'd3;
    localparam logic [2:0] ST_JMS = 3'd4;
    localparam logic [2:0] ST_FIM = 3'd5;

    logic [2:0]        state;
    logic              cond;
    logic [3:0]        hi;
    logic              condRaw;
    logic              lastX;
    logic [ADDR_W-1:0] pageAddr;
    logic [ADDR_W-1:0] longAddr;
    logic              unusedAcc;

    // Only the low BANK_W accumulator bits feed the bank register.
    assign unusedAcc = ^accIn;

    assign lastX = (cycle == 3'd7);

    always_comb begin
        condRaw = (~testPin & opa[0]) | (carryFlag & opa[1]) | (zeroFlag & opa[2]);
    end
    assign ccOut = opa[3] ? ~condRaw : condRaw;

    // Targets are built by overlaying the operand fields onto pcIn, so any
    // address bits above the overlaid field pass straight through without
    // needing a width-dependent slice.
    always_comb begin
        pageAddr       = pcIn;
        pageAddr[7:0]  = {opr, opa};
        longAddr       = pcIn;
        longAddr[11:0] = {hi, opr, opa};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= ST_W1;
            cond       <= 1'b0;
            hi         <= 4'h0;
            carryFlag  <= 1'b0;
            zeroFlag   <= 1'b0;
            secondWord <= 1'b0;
            jumpTaken  <= 1'b0;
            jmsPush    <= 1'b0;
            jumpAddr   <= '0;
            bankSel    <= '0;
            bankSelStb <= 1'b0;
        end else begin
            jumpTaken  <= 1'b0;
            jmsPush    <= 1'b0;
            bankSelStb <= 1'b0;
            if (lastX) begin
                if (state == ST_W1) begin
                    // ccOut here still reflects the old flags, so a JCN that
                    // coincides with a flag write sees the pre-update values.
                    if (flagWe) begin
                        carryFlag <= carryNext;
                        zeroFlag  <= zeroNext;
                    end
                    if (opr == 4'hF && opa == 4'hD) begin
                        bankSel    <= accIn[BANK_W-1:0];
                        bankSelStb <= 1'b1;
                    end
                    case (opr)
                        4'h1: begin
                            state      <= ST_JCN;
                            cond       <= ccOut;
                            secondWord <= 1'b1;
                        end
                        4'h7: begin
                            state      <= ST_ISZ;
                            cond       <= ~regZeroIn;
                            secondWord <= 1'b1;
                        end
                        4'h4: begin
                            state      <= ST_JUN;
                            hi         <= opa;
                            secondWord <= 1'b1;
                        end
                        4'h5: begin
                            state      <= ST_JMS;
                            hi         <= opa;
                            secondWord <= 1'b1;
                        end
                        4'h2: begin
                            if (!opa[0]) begin
                                state      <= ST_FIM;
                                secondWord <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    // Operand word: never decoded as an instruction.
                    state      <= ST_W1;
                    secondWord <= 1'b0;
                    case (state)
                        ST_JCN, ST_ISZ: begin
                            if (cond) begin
                                jumpTaken <= 1'b1;
                                jumpAddr  <= pageAddr;
                            end
                        end
                        ST_JUN: begin
                            jumpTaken <= 1'b1;
                            jumpAddr  <= longAddr;
                        end
                        ST_JMS: begin
                            jumpTaken <= 1'b1;
                            jmsPush   <= 1'b1;
                            jumpAddr  <= longAddr;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cc_branch_unit.sv
module tb_cc_branch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  cycle;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        testPin;
    logic        flagWe;
    logic        carryNext;
    logic        zeroNext;
    logic        regZeroIn;
    logic [3:0]  accIn;
    logic [11:0] pcIn;
    logic        carryFlag;
    logic        zeroFlag;
    logic        ccOut;
    logic        secondWord;
    logic        jumpTaken;
    logic        jmsPush;
    logic [11:0] jumpAddr;
    logic [2:0]  bankSel;
    logic        bankSelStb;

    cc_branch_unit #(.DATA_W(4), .ADDR_W(12), .BANK_W(3)) dut (
        .clk(clk), .rstN(rstN), .cycle(cycle), .opr(opr), .opa(opa),
        .testPin(testPin), .flagWe(flagWe), .carryNext(carryNext),
        .zeroNext(zeroNext), .regZeroIn(regZeroIn), .accIn(accIn), .pcIn(pcIn),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag), .ccOut(ccOut),
        .secondWord(secondWord), .jumpTaken(jumpTaken), .jmsPush(jmsPush),
        .jumpAddr(jumpAddr), .bankSel(bankSel), .bankSelStb(bankSelStb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        jms;
    } jumpExp_t;

    jumpExp_t   jumpQ[$];
    logic [2:0] bankQ[$];
    int total = 0;
    int bad   = 0;
    int runLen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8-clock ROM word; inputs change 1ns after each rising edge.
    task automatic word(input logic [3:0] o, input logic [3:0] a, input logic [11:0] pc);
        opr  = o;
        opa  = a;
        pcIn = pc;
        for (int c = 0; c < 8; c++) begin
            cycle = c[2:0];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!rstN) begin
            runLen = 0;
        end else begin
            if (jumpTaken) begin
                if (jumpQ.size() == 0) begin
                    chk("jump_unexpected", {20'd0, jumpAddr}, 32'hFFFF_FFFF);
                end else begin
                    jumpExp_t e;
                    e = jumpQ.pop_front();
                    chk("jump_addr", {20'd0, jumpAddr}, {20'd0, e.addr});
                    chk("jms_push", {31'd0, jmsPush}, {31'd0, e.jms});
                end
            end else if (jmsPush) begin
                chk("jms_without_jump", 32'd1, 32'd0);
            end
            if (bankSelStb) begin
                if (bankQ.size() == 0) begin
                    chk("bank_unexpected", {29'd0, bankSel}, 32'hFFFF_FFFF);
                end else begin
                    logic [2:0] b;
                    b = bankQ.pop_front();
                    chk("bank_sel", {29'd0, bankSel}, {29'd0, b});
                end
            end
            if (secondWord) begin
                runLen++;
            end else if (runLen != 0) begin
                chk("second_word_len", runLen, 32'd8);
                runLen = 0;
            end
        end
    end

    initial begin
        rstN = 1'b0; cycle = 3'd0; opr = 4'h0; opa = 4'h0; testPin = 1'b1;
        flagWe = 1'b0; carryNext = 1'b0; zeroNext = 1'b0; regZeroIn = 1'b0;
        accIn = 4'h0; pcIn = 12'h000;
        #1;
        chk("rst_carry", {31'd0, carryFlag}, 32'd0);
        chk("rst_zero", {31'd0, zeroFlag}, 32'd0);
        chk("rst_second", {31'd0, secondWord}, 32'd0);
        chk("rst_jump", {31'd0, jumpTaken}, 32'd0);
        chk("rst_addr", {20'd0, jumpAddr}, 32'd0);
        chk("rst_bank", {29'd0, bankSel}, 32'd0);
        chk("rst_stb", {31'd0, bankSelStb}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        // Reset in the middle of a JUN operand word: no jump may follow.
        word(4'h4, 4'hA, 12'h100);
        chk("jun_second_on", {31'd0, secondWord}, 32'd1);
        opr = 4'hB; opa = 4'hC; pcIn = 12'h101;
        for (int c = 0; c < 3; c++) begin
            cycle = c[2:0];
            @(posedge clk);
            #1;
        end
        cycle = 3'd3;
        rstN = 1'b0;
        #1;
        chk("rst_mid_second", {31'd0, secondWord}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        word(4'h0, 4'h0, 12'h102);
        chk("after_rst_second", {31'd0, secondWord}, 32'd0);

        // Set carry through the ALU strobe (non-special opcode).
        flagWe = 1'b1; carryNext = 1'b1; zeroNext = 1'b0;
        word(4'hF, 4'h2, 12'h200);
        flagWe = 1'b0;
        chk("carry_set", {31'd0, carryFlag}, 32'd1);

        // JCN on carry: second word at 0x5FF -> 0x534.
        opr = 4'h1; opa = 4'h2; #1;
        chk("cc_carry", {31'd0, ccOut}, 32'd1);
        jumpQ.push_back('{addr: 12'h534, jms: 1'b0});
        word(4'h1, 4'h2, 12'h5FE);
        flagWe = 1'b1; carryNext = 1'b0;          // must be ignored in W2
        word(4'h3, 4'h4, 12'h5FF);
        flagWe = 1'b0;
        chk("flag_ignored_w2", {31'd0, carryFlag}, 32'd1);

        // Inverted condition: no jump, jumpAddr holds.
        opa = 4'hA; #1;
        chk("cc_inverted", {31'd0, ccOut}, 32'd0);
        word(4'h1, 4'hA, 12'h600);
        word(4'h3, 4'h4, 12'h601);
        word(4'h0, 4'h0, 12'h602);
        chk("jcn_false_hold", {20'd0, jumpAddr}, 32'h534);

        // JCN on TEST low at 0x2FF lands in the next page.
        testPin = 1'b0;
        jumpQ.push_back('{addr: 12'h380, jms: 1'b0});
        word(4'h1, 4'h1, 12'h2FF);
        word(4'h8, 4'h0, 12'h300);
        testPin = 1'b1;

        // JMS with jmsPush; operand word run length checked by the monitor.
        jumpQ.push_back('{addr: 12'hC21, jms: 1'b1});
        word(4'h5, 4'hC, 12'h120);
        word(4'h2, 4'h1, 12'h121);

        // ISZ: register reached zero -> fall through; otherwise jump in page.
        regZeroIn = 1'b1;
        word(4'h7, 4'h3, 12'h4A0);
        regZeroIn = 1'b0;
        word(4'h1, 4'h0, 12'h4A1);
        jumpQ.push_back('{addr: 12'h410, jms: 1'b0});
        word(4'h7, 4'h3, 12'h4A6);
        word(4'h1, 4'h0, 12'h4A7);

        // DCL: only the low three accumulator bits are taken.
        accIn = 4'hE;
        bankQ.push_back(3'b110);
        word(4'hF, 4'hD, 12'h050);
        chk("dcl_bank", {29'd0, bankSel}, 32'h6);
        // FIM operand 0xFD must not act as DCL; 0x1F operand must not start JCN.
        accIn = 4'h1;
        word(4'h2, 4'h0, 12'h051);
        word(4'hF, 4'hD, 12'h052);
        chk("fim_no_dcl", {29'd0, bankSel}, 32'h6);
        word(4'h2, 4'h2, 12'h053);
        word(4'h1, 4'hF, 12'h054);
        word(4'h0, 4'h0, 12'h055);
        chk("operand_not_jcn", {31'd0, secondWord}, 32'd0);

        // Flag write coincident with JCN: condition uses the old carry.
        flagWe = 1'b1; carryNext = 1'b0; zeroNext = 1'b1;
        jumpQ.push_back('{addr: 12'h7AB, jms: 1'b0});
        word(4'h1, 4'h2, 12'h7A0);
        flagWe = 1'b0;
        chk("coinc_carry", {31'd0, carryFlag}, 32'd0);
        chk("coinc_zero", {31'd0, zeroFlag}, 32'd1);
        word(4'hA, 4'hB, 12'h7A1);

        // JUN after reset-free operation: long jump.
        jumpQ.push_back('{addr: 12'h9EF, jms: 1'b0});
        word(4'h4, 4'h9, 12'h010);
        word(4'hE, 4'hF, 12'h011);
        word(4'h0, 4'h0, 12'h012);
        word(4'h0, 4'h0, 12'h013);

        chk("jump_queue_empty", jumpQ.size(), 32'd0);
        chk("bank_queue_empty", bankQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
